// File: rtl/multdiv_seq_if.sv
// EX-stage <-> mult/div sequencer bundle.
// Carries issue intent, HI/LO read select and the sequencer status back.
interface multdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             rd_req_i;
    logic             hl_sel_i;
    logic [WIDTH-1:0] hl_data_o;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, rd_req_i, hl_sel_i,
        input  hl_data_o, busy_o, stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, rd_req_i, hl_sel_i,
        output hl_data_o, busy_o, stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed MULT / restoring DIV sequencer owning HI/LO.
// Works on magnitudes for WIDTH steps, then fixes signs in one cycle.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    multdiv_seq_if.slave  bus
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] abs_a, abs_b, add_in, quot_s, rem_s;
    logic [WIDTH:0]   add_sum, rem_ext, trial;
    logic [W2-1:0]    prod_s;

    always_comb begin
        abs_a   = bus.a_i[WIDTH-1] ? -bus.a_i : bus.a_i;
        abs_b   = bus.b_i[WIDTH-1] ? -bus.b_i : bus.b_i;
        add_in  = acc_q[0] ? opnd_q : '0;
        add_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, add_in};
        // Shifted remainder needs one extra bit before the trial subtract
        rem_ext = acc_q[W2-1:WIDTH-1];
        trial   = rem_ext - {1'b0, opnd_q};
        prod_s  = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot_s  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_s   = sa_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start_i) begin
                    op_d  = bus.op_i;
                    sa_d  = bus.a_i[WIDTH-1];
                    sb_d  = bus.b_i[WIDTH-1];
                    cnt_d = '0;
                    if (bus.op_i && bus.b_i == '0) begin
                        hi_d    = bus.a_i;
                        lo_d    = '1;
                        state_d = DONE;
                    end else if (bus.op_i) begin
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        opnd_d  = abs_b;
                        state_d = CALC;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        opnd_d  = abs_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (op_q) begin
                    acc_d = trial[WIDTH]
                          ? {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {add_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = SIGN;
            end
            SIGN: begin
                if (op_q) begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                end else begin
                    {hi_d, lo_d} = prod_s;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC) || (state_d == SIGN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.stall_o   = busy_q & (bus.start_i | bus.rd_req_i);
    assign bus.hl_data_o = bus.hl_sel_i ? hi_q : lo_q;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: latency, signed results, stalls,
// back-to-back issue and mid-operation reset.
module tb_multdiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    multdiv_seq_if #(.WIDTH(32)) bus ();

    multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        tick();
        bus.start_i = 1'b0;
    endtask

    // Cycles 1..33 after the start edge must be busy with no done pulse
    task automatic busy_span(input string tag);
        int bad = 0;
        for (int c = 0; c < 33; c++) begin
            if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) bad++;
            tick();
        end
        chk(tag, bad, 0);
    endtask

    task automatic done_chk(input string tag, input logic [31:0] hi,
                            input logic [31:0] lo);
        chk({tag, "_done"}, {31'd0, bus.done_o}, 1);
        chk({tag, "_busy"}, {31'd0, bus.busy_o}, 0);
        chk({tag, "_hi"}, bus.hi_o, hi);
        chk({tag, "_lo"}, bus.lo_o, lo);
    endtask

    task automatic run_op(input string tag, input logic op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        issue(op, a, b);
        busy_span({tag, "_span"});
        done_chk(tag, hi, lo);
        tick();
        chk({tag, "_idle"}, {31'd0, bus.done_o}, 0);
    endtask

    initial begin
        int bad;
        bus.start_i  = 1'b0;
        bus.op_i     = 1'b0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.rd_req_i = 1'b0;
        bus.hl_sel_i = 1'b0;
        tick();
        tick();
        chk("rst_hi", bus.hi_o, 0);
        chk("rst_lo", bus.lo_o, 0);
        chk("rst_busy", {31'd0, bus.busy_o}, 0);
        chk("rst_done", {31'd0, bus.done_o}, 0);
        rst = 1'b0;
        tick();

        run_op("mul_7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2", 1'b1, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD);

        // Divide by zero completes in one cycle without busy
        issue(1'b1, 32'd5, 32'd0);
        done_chk("div_5d0", 32'd5, 32'hFFFF_FFFF);
        tick();
        chk("div_5d0_idle", {31'd0, bus.done_o}, 0);

        run_op("mul_min", 1'b0, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0);
        run_op("div_min", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0, 32'h8000_0000);

        // 0x66 * 0x2AAAAAAB = 0x11_00000022 preloads HI/LO
        run_op("preload", 1'b0, 32'h66, 32'h2AAA_AAAB,
               32'h11, 32'h22);

        bus.rd_req_i = 1'b1;
        bus.hl_sel_i = 1'b0;
        bus.start_i  = 1'b1;
        bus.op_i     = 1'b0;
        bus.a_i      = 32'd3;
        bus.b_i      = 32'd4;
        #1;
        chk("rd_start_stall", {31'd0, bus.stall_o}, 0);
        chk("rd_start_data", bus.hl_data_o, 32'h22);
        tick();
        bus.start_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 33; c++) begin
            if (bus.stall_o !== 1'b1 || bus.hl_data_o !== 32'h22) bad++;
            tick();
        end
        chk("rd_busy_stall", bad, 0);
        chk("rd_done_stall", {31'd0, bus.stall_o}, 0);
        chk("rd_done_done", {31'd0, bus.done_o}, 1);
        chk("rd_done_lo", bus.hl_data_o, 32'h0C);
        bus.hl_sel_i = 1'b1;
        #1;
        chk("rd_done_hi", bus.hl_data_o, 32'h0);
        bus.rd_req_i = 1'b0;
        tick();

        // Second start held through busy must be ignored until DONE
        issue(1'b0, 32'd5, 32'd6);
        bus.start_i = 1'b1;
        bus.op_i    = 1'b1;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        bad = 0;
        for (int c = 0; c < 33; c++) begin
            if (bus.stall_o !== 1'b1 || bus.busy_o !== 1'b1) bad++;
            tick();
        end
        chk("b2b_stall", bad, 0);
        chk("b2b_first_stall", {31'd0, bus.stall_o}, 0);
        done_chk("b2b_first", 32'd0, 32'd30);
        tick();
        bus.start_i = 1'b0;
        busy_span("b2b_second_span");
        done_chk("b2b_second", 32'd2, 32'd14);
        tick();

        // Reset in CALC cycle 10 aborts and clears HI/LO
        issue(1'b0, 32'd7, 32'd9);
        for (int c = 1; c < 10; c++) tick();
        chk("abort_busy_pre", {31'd0, bus.busy_o}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_hi", bus.hi_o, 0);
        chk("abort_lo", bus.lo_o, 0);
        chk("abort_busy", {31'd0, bus.busy_o}, 0);
        chk("abort_done", {31'd0, bus.done_o}, 0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) bad++;
            tick();
        end
        chk("abort_quiet", bad, 0);
        chk("abort_hi_after", bus.hi_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
